// File: rtl/branch_pkg.sv
// Shared constants for the IPPro branch unit: {type,op} branch codes, their
// one-hot condition masks and the decoder that maps one to the other.
package branch_pkg;

    localparam int FLAGS_LENGTH = 8;

    // Bit positions in the condition mask {NGT,NS,NEQ,NZ,GT,S,EQ,Z}
    localparam int Z_IDX   = 0;
    localparam int EQ_IDX  = 1;
    localparam int S_IDX   = 2;
    localparam int GT_IDX  = 3;
    localparam int NZ_IDX  = 4;
    localparam int NEQ_IDX = 5;
    localparam int NS_IDX  = 6;
    localparam int NGT_IDX = 7;

    localparam logic [7:0] BNEQ = 8'h81;
    localparam logic [7:0] BEQ  = 8'h82;
    localparam logic [7:0] BZ   = 8'h83;
    localparam logic [7:0] BNZ  = 8'h84;
    localparam logic [7:0] BS   = 8'h85;
    localparam logic [7:0] BNGT = 8'h86;
    localparam logic [7:0] BGT  = 8'h87;
    localparam logic [7:0] BNS  = 8'h88;

    localparam logic [FLAGS_LENGTH-1:0] BZ_MASK   = 8'h01;
    localparam logic [FLAGS_LENGTH-1:0] BEQ_MASK  = 8'h02;
    localparam logic [FLAGS_LENGTH-1:0] BS_MASK   = 8'h04;
    localparam logic [FLAGS_LENGTH-1:0] BGT_MASK  = 8'h08;
    localparam logic [FLAGS_LENGTH-1:0] BNZ_MASK  = 8'h10;
    localparam logic [FLAGS_LENGTH-1:0] BNEQ_MASK = 8'h20;
    localparam logic [FLAGS_LENGTH-1:0] BNS_MASK  = 8'h40;
    localparam logic [FLAGS_LENGTH-1:0] BNGT_MASK = 8'h80;

    // Non-branch codes decode to an empty mask, which doubles as "not valid"
    function automatic logic [FLAGS_LENGTH-1:0] decode_mask(input logic [7:0] code);
        logic [FLAGS_LENGTH-1:0] mask;
        case (code)
            BZ:      mask = BZ_MASK;
            BEQ:     mask = BEQ_MASK;
            BS:      mask = BS_MASK;
            BGT:     mask = BGT_MASK;
            BNZ:     mask = BNZ_MASK;
            BNEQ:    mask = BNEQ_MASK;
            BNS:     mask = BNS_MASK;
            BNGT:    mask = BNGT_MASK;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/branch_unit_param_branch_delay_stage.sv
// One pipeline register stage holding {valid, mask, addr}; clear only drops
// the valid bit since the payload is meaningless once invalid.
import branch_pkg::*;

module branch_delay_stage #(
    parameter int ADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    valid_in,
    input  logic [FLAGS_LENGTH-1:0] mask_in,
    input  logic [ADDR_W-1:0]       addr_in,
    output logic                    valid_out,
    output logic [FLAGS_LENGTH-1:0] mask_out,
    output logic [ADDR_W-1:0]       addr_out
);

    logic                    valid_q, valid_d;
    logic [FLAGS_LENGTH-1:0] mask_q, mask_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;

    always_comb begin
        valid_d = valid_q;
        mask_d  = mask_q;
        addr_d  = addr_q;
        if (en) begin
            valid_d = valid_in;
            mask_d  = mask_in;
            addr_d  = addr_in;
        end
        if (clr) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            mask_q  <= '0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            mask_q  <= mask_d;
            addr_q  <= addr_d;
        end
    end

    assign valid_out = valid_q;
    assign mask_out  = mask_q;
    assign addr_out  = addr_q;

endmodule

// File: rtl/branch_unit_param.sv
// Branch handler: decodes branches, delays them DEPTH stages, resolves them
// against live ALU flags, pulses BR_TAKEN and squashes younger branches.
import branch_pkg::*;

module branch_unit_param #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 3,
    parameter int CNT_W  = 16
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    input  logic                    FLUSH,
    input  logic [2:0]              INSTR_TYPE,
    input  logic [4:0]              OPCODE,
    input  logic [ADDR_W-1:0]       BADDR_IN,
    input  logic [3:0]              ALU_FLAGS,
    output logic [FLAGS_LENGTH-1:0] IM_FLAGS,
    output logic                    BR_TAKEN,
    output logic [ADDR_W-1:0]       BADDR_OUT,
    output logic                    BR_PENDING,
    output logic [CNT_W-1:0]        TAKEN_CNT
);

    // Index 0 is the combinational decode; index k is register stage k
    logic [DEPTH:0]          valid_s;
    logic [FLAGS_LENGTH-1:0] mask_s [DEPTH+1];
    logic [ADDR_W-1:0]       addr_s [DEPTH+1];

    logic                    hit;
    logic                    clear;
    logic [FLAGS_LENGTH-1:0] ext_flags;
    logic [DEPTH:1]          valid_nx;

    logic              br_taken_q, br_taken_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;

    assign mask_s[0]  = decode_mask({INSTR_TYPE, OPCODE});
    assign valid_s[0] = |mask_s[0];
    assign addr_s[0]  = BADDR_IN;

    assign ext_flags = {~ALU_FLAGS, ALU_FLAGS};
    assign hit       = valid_s[DEPTH] & |(mask_s[DEPTH] & ext_flags);
    assign clear     = FLUSH | (ENABLE & hit);

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        branch_delay_stage #(
            .ADDR_W(ADDR_W)
        ) u_stage (
            .clk      (CLK),
            .rst_n    (RESET),
            .en       (ENABLE),
            .clr      (clear),
            .valid_in (valid_s[k-1]),
            .mask_in  (mask_s[k-1]),
            .addr_in  (addr_s[k-1]),
            .valid_out(valid_s[k]),
            .mask_out (mask_s[k]),
            .addr_out (addr_s[k])
        );
    end

    // Mirrors the stage update so BR_PENDING lines up with the new valid bits
    always_comb begin
        valid_nx = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (clear) begin
                valid_nx[k] = 1'b0;
            end else if (ENABLE) begin
                valid_nx[k] = valid_s[k-1];
            end else begin
                valid_nx[k] = valid_s[k];
            end
        end
    end

    always_comb begin
        br_taken_d = 1'b0;
        baddr_d    = baddr_q;
        cnt_d      = cnt_q;
        pending_d  = |valid_nx;
        if (ENABLE && hit) begin
            br_taken_d = 1'b1;
            baddr_d    = addr_s[DEPTH];
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            br_taken_q <= 1'b0;
            baddr_q    <= '0;
            cnt_q      <= '0;
            pending_q  <= 1'b0;
        end else begin
            br_taken_q <= br_taken_d;
            baddr_q    <= baddr_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
        end
    end

    assign IM_FLAGS   = valid_s[DEPTH] ? mask_s[DEPTH] : '0;
    assign BR_TAKEN   = br_taken_q;
    assign BADDR_OUT  = baddr_q;
    assign BR_PENDING = pending_q;
    assign TAKEN_CNT  = cnt_q;

endmodule

// File: doc/branch_unit_param.md
Name: branch_unit_param

Overview:
Parametrised branch handler for the IPPro datapath. It decodes branch instructions into a condition mask and carries the mask, a valid bit and the target address through a pipeline of configurable depth. At the evaluation stage it resolves the condition against the live ALU flags and issues a one-cycle taken pulse with the target address. On a taken branch it squashes younger in-flight branches, and it counts taken branches.

Parameters:
ADDR_W, 10, branch target address width
DEPTH, 3, register stages from decode to evaluation (min 1)
CNT_W, 16, width of the taken-branch counter

Ports:
CLK  in  1  clock; all logic on rising edge
RESET  in  1  synchronous, active-low reset
ENABLE  in  1  pipeline advance; low freezes all stage registers
FLUSH  in  1  clears all in-flight valid bits; acts regardless of ENABLE
INSTR_TYPE  in  3  instruction class
OPCODE  in  5  instruction opcode
BADDR_IN  in  ADDR_W  branch target, aligned with INSTR_TYPE/OPCODE
ALU_FLAGS  in  4  {GT,S,EQ,Z} from ALU, sampled at evaluation cycle
IM_FLAGS  out  8  condition mask at evaluation stage (0 if stage invalid)
BR_TAKEN  out  1  one-cycle taken pulse
BADDR_OUT  out  ADDR_W  target of last taken branch; holds between pulses
BR_PENDING  out  1  OR of all stage valid bits
TAKEN_CNT  out  CNT_W  saturating count of taken branches

Behaviour:
- Reset (RESET==0 at edge): every stage mask, valid bit and address is cleared. IM_FLAGS=0, BR_TAKEN=0, BADDR_OUT=0, BR_PENDING=0, TAKEN_CNT=0.
- RESET overrides FLUSH and ENABLE.
- Decode (combinational) of {INSTR_TYPE,OPCODE} to an 8-bit one-hot mask over bits {NGT,NS,NEQ,NZ,GT,S,EQ,Z} (bit7..0):
  - 8'h83 BZ -> bit0
  - 8'h82 BEQ -> bit1
  - 8'h85 BS -> bit2
  - 8'h87 BGT -> bit3
  - 8'h84 BNZ -> bit4
  - 8'h81 BNEQ -> bit5
  - 8'h88 BNS -> bit6
  - 8'h86 BNGT -> bit7
  - Any other code: mask 0, valid 0.
- Stage 1 captures mask, valid=(mask!=0) and BADDR_IN on an ENABLE edge. Stage k captures stage k-1 on each ENABLE edge.
- IM_FLAGS equals stage DEPTH mask gated by its valid bit. Latency is DEPTH enabled cycles from instruction to IM_FLAGS.
- Evaluation, combinational at stage DEPTH: ext = {~GT,~S,~EQ,~Z,GT,S,EQ,Z}; hit = valid_D & |(mask_D & ext).
- On an ENABLE edge with hit=1:
  - BR_TAKEN<=1
  - BADDR_OUT<=addr_D (latency DEPTH+1 from BADDR_IN)
  - TAKEN_CNT increments, saturating at all-ones (no wrap)
  - Squash: valid bits of stages 1..DEPTH are cleared instead of shifted in, and the instruction decoded this cycle is discarded.
- On an ENABLE edge with hit=0: BR_TAKEN<=0 and BADDR_OUT holds.
- ENABLE low: stages and BADDR_OUT hold; BR_TAKEN<=0, so the pulse is never repeated; ALU_FLAGS are ignored.
- FLUSH=1 at an edge: all valid bits are cleared.
  - If ENABLE and hit are also 1, the taken pulse, address and count update still occur; FLUSH only removes younger entries.
  - Stage addresses are don't-care when the entry is invalid.
- Back-to-back branches in consecutive cycles: the first taken branch squashes the rest. Not-taken branches do not squash.
- BR_PENDING is registered, computed from next-state valid bits.

Decomposition:
- Package branch_pkg holds:
  - FLAGS_LENGTH=8
  - opcode constants BZ..BNGT as 8-bit {type,op} codes
  - one-hot masks BZ_MASK..BNGT_MASK
  - flag bit index constants
- One sub-module, branch_delay_stage: a single register stage of {valid,mask,addr} with enable, synchronous clear and active-low reset. It is instantiated DEPTH times via generate.

Test Plan:
- Reset: hold RESET=0 for 3 cycles with random inputs -> all outputs 0. Release -> BR_PENDING stays 0 with no branches.
- BZ taken, DEPTH=3: inject 8'h83, BADDR_IN=10'h155, ALU_FLAGS Z=1 at the evaluation cycle -> IM_FLAGS=8'h01 3 cycles later; BR_TAKEN=1 for exactly 1 cycle at +4; BADDR_OUT=10'h155; TAKEN_CNT=1.
- BNZ not taken: 8'h84 with Z=1 at evaluation -> IM_FLAGS=8'h10, BR_TAKEN stays 0, BADDR_OUT unchanged, count unchanged.
- Squash: BEQ (EQ=1) followed next cycle by BGT (GT=1) -> a single pulse for the first target; the second never reaches IM_FLAGS; TAKEN_CNT +1.
- Stall and flush: drop ENABLE for 5 cycles mid-flight -> outputs frozen, no BR_TAKEN. Then assert FLUSH -> BR_PENDING=0 next cycle, and no later pulse.
- Saturation: CNT_W=4, issue 18 taken BS branches (S=1) -> TAKEN_CNT reaches 4'hF and stays there.
